// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decoder handshake.
// The fetch unit is the master; memory and decoder together form the slave side.
interface instruction_fetch_if #(
    parameter int unsigned WORD_SIZE = 32
);
    // Memory read port
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ready;
    logic [WORD_SIZE-1:0] mem_data;

    // Decoder handshake
    logic                 instr_valid;
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] instr_pc;
    logic                 instr_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads the word at the current PC, holds it for the
// decoder, and steers the program counter (advance on accept, load on redirect).
module instruction_fetch #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned INSTR_STEP = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,

    // Program counter
    input  logic [WORD_SIZE-1:0] pc_value,
    output logic                 pc_update_enable,
    output logic                 pc_set_enable,
    output logic [WORD_SIZE-1:0] pc_operand,

    // Control
    input  logic                 fetch_enable,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_target,
    output logic [WORD_SIZE-1:0] instr_count,

    // Memory and decoder
    instruction_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e               state_q;
    logic [WORD_SIZE-1:0] instr_q;
    logic [WORD_SIZE-1:0] instr_pc_q;
    logic [WORD_SIZE-1:0] count_q;

    logic redirect_act;
    logic mem_req;
    logic instr_valid;
    logic capture;
    logic accept;

    // Handshake and PC-control decode; redirect overrides everything outside IDLE
    always_comb begin
        redirect_act = redirect && (state_q != StIdle);
        mem_req      = (state_q == StFetch) && fetch_enable && !redirect;
        instr_valid  = (state_q == StHold) && !redirect;
        capture      = mem_req && bus.mem_ready;
        accept       = instr_valid && bus.instr_ready;

        pc_set_enable    = redirect_act;
        pc_update_enable = accept;
        pc_operand       = redirect_act ? redirect_target : WORD_SIZE'(INSTR_STEP);
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = pc_value;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign instr_count     = count_q;

    // Fetch FSM with the held word and the accepted-instruction counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                end
                StFetch: begin
                    if (capture) begin
                        instr_q    <= bus.mem_data;
                        instr_pc_q <= pc_value;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    // A redirect discards the held word; the PC is reloaded this edge
                    if (redirect) begin
                        state_q <= StFetch;
                    end else if (accept) begin
                        count_q <= count_q + 1'b1;
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios, then randomized traffic
// checked against a transaction-level model of the expected PC and count.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        rst2_n = 1'b1;

    logic [31:0] pc = 32'h0;
    logic        pc_update_enable;
    logic        pc_set_enable;
    logic [31:0] pc_operand;
    logic        fetch_enable;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr_count;

    instruction_fetch_if #(.WORD_SIZE(32)) bus ();

    // Narrow instance to exercise counter wrap-around
    logic [3:0]  pc2 = 4'h0;
    logic        pc2_update;
    logic        pc2_set;
    logic [3:0]  pc2_operand;
    logic [3:0]  count2;
    int          e2 = 0;

    instruction_fetch_if #(.WORD_SIZE(4)) bus2 ();

    instruction_fetch #(.WORD_SIZE(32), .INSTR_STEP(1)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pc_value         (pc),
        .pc_update_enable (pc_update_enable),
        .pc_set_enable    (pc_set_enable),
        .pc_operand       (pc_operand),
        .fetch_enable     (fetch_enable),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .instr_count      (instr_count),
        .bus              (bus.master)
    );

    instruction_fetch #(.WORD_SIZE(4), .INSTR_STEP(1)) dut2 (
        .clock            (clock),
        .reset_n          (rst2_n),
        .pc_value         (pc2),
        .pc_update_enable (pc2_update),
        .pc_set_enable    (pc2_set),
        .pc_operand       (pc2_operand),
        .fetch_enable     (1'b1),
        .redirect         (1'b0),
        .redirect_target  (4'h0),
        .instr_count      (count2),
        .bus              (bus2.master)
    );

    initial forever #5 clock = ~clock;

    // Program counters and memories of the environment
    always @(posedge clock) begin
        if (pc_set_enable) pc <= pc_operand;
        else if (pc_update_enable) pc <= pc + pc_operand;
        if (pc2_set) pc2 <= pc2_operand;
        else if (pc2_update) pc2 <= pc2 + pc2_operand;
        if (rst2_n) e2 <= e2 + 1;
    end

    assign bus.mem_data     = bus.mem_addr ^ 32'hA5;
    assign bus2.mem_data    = bus2.mem_addr ^ 4'h5;
    assign bus2.mem_ready   = 1'b1;
    assign bus2.instr_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] model_pc;
    logic [31:0] model_count;
    int          accepts;

    initial begin
        fetch_enable    = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        bus.mem_ready   = 1'b0;
        bus.instr_ready = 1'b0;

        // Reset: all control outputs and registers cleared
        #2 reset_n = 1'b0;
        rst2_n = 1'b0;
        #1;
        chk("rst_req", bus.mem_req, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_upd", pc_update_enable, 0);
        chk("rst_set", pc_set_enable, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_count", instr_count, 0);
        fetch_enable    = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.instr_ready = 1'b1;
        redirect        = 1'b1;
        #1;
        chk("rst_req_en", bus.mem_req, 0);
        chk("rst_set_redir", pc_set_enable, 0);
        redirect = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        rst2_n  = 1'b1;
        #1;
        chk("idle_req", bus.mem_req, 0);
        chk("idle_valid", bus.instr_valid, 0);
        cyc();

        // 1: streaming at one instruction per two cycles
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_req", bus.mem_req, 1);
            chk("t1_addr", bus.mem_addr, i);
            chk("t1_nvalid", bus.instr_valid, 0);
            cyc();
            #1;
            chk("t1_valid", bus.instr_valid, 1);
            chk("t1_instr", bus.instr, i ^ 32'hA5);
            chk("t1_instr_pc", bus.instr_pc, i);
            chk("t1_upd", pc_update_enable, 1);
            chk("t1_operand", pc_operand, 1);
            cyc();
        end
        #1;
        chk("t1_count", instr_count, 4);

        // 2: memory stall keeps the request stable
        bus.mem_ready   = 1'b0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_req", bus.mem_req, 1);
            chk("t2_addr", bus.mem_addr, 4);
            chk("t2_upd", pc_update_enable, 0);
            chk("t2_nvalid", bus.instr_valid, 0);
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("t2_req_last", bus.mem_req, 1);
        chk("t2_addr_last", bus.mem_addr, 4);
        cyc();
        #1;
        chk("t2_valid", bus.instr_valid, 1);
        chk("t2_instr_pc", bus.instr_pc, 4);

        // 3: decoder stall holds the word
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_valid", bus.instr_valid, 1);
            chk("t3_instr", bus.instr, 32'h4 ^ 32'hA5);
            chk("t3_instr_pc", bus.instr_pc, 4);
            chk("t3_upd", pc_update_enable, 0);
            cyc();
        end
        bus.instr_ready = 1'b1;
        #1;
        chk("t3_upd_pulse", pc_update_enable, 1);
        cyc();
        #1;
        chk("t3_upd_off", pc_update_enable, 0);
        chk("t3_addr_next", bus.mem_addr, 5);
        chk("t3_count", instr_count, 5);
        chk("t3_pc", pc, 5);

        // 4: redirect while holding a word
        cyc();
        redirect        = 1'b1;
        redirect_target = 32'h40;
        #1;
        chk("t4_set", pc_set_enable, 1);
        chk("t4_operand", pc_operand, 32'h40);
        chk("t4_valid", bus.instr_valid, 0);
        chk("t4_upd", pc_update_enable, 0);
        chk("t4_req", bus.mem_req, 0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("t4_count", instr_count, 5);
        chk("t4_req_next", bus.mem_req, 1);
        chk("t4_addr_next", bus.mem_addr, 32'h40);
        chk("t4_set_off", pc_set_enable, 0);

        // 5: redirect in FETCH blocks the capture
        redirect        = 1'b1;
        redirect_target = 32'h80;
        #1;
        chk("t5_req", bus.mem_req, 0);
        chk("t5_set", pc_set_enable, 1);
        cyc();
        redirect = 1'b0;
        #1;
        chk("t5_nvalid", bus.instr_valid, 0);
        chk("t5_req_next", bus.mem_req, 1);
        chk("t5_addr_next", bus.mem_addr, 32'h80);
        bus.instr_ready = 1'b0;
        cyc();
        #1;
        chk("t5_valid", bus.instr_valid, 1);
        chk("t5_instr_pc", bus.instr_pc, 32'h80);

        // 6: asynchronous reset in HOLD
        reset_n = 1'b0;
        #1;
        chk("t6_valid", bus.instr_valid, 0);
        chk("t6_req", bus.mem_req, 0);
        chk("t6_count", instr_count, 0);
        cyc();
        reset_n = 1'b1;
        #1;
        chk("t6_idle_req", bus.mem_req, 0);
        cyc();
        #1;
        chk("t6_req", bus.mem_req, 1);
        chk("t6_addr", bus.mem_addr, 32'h80);

        // Randomized traffic against the PC/count model
        model_pc    = 32'h80;
        model_count = 32'h0;
        accepts     = 0;
        for (int n = 0; n < 400; n++) begin
            cyc();
            fetch_enable    = ($urandom_range(9) != 0);
            bus.mem_ready   = ($urandom_range(9) < 6);
            bus.instr_ready = ($urandom_range(9) < 6);
            redirect        = ($urandom_range(11) == 0);
            redirect_target = $urandom;
            #1;
            chk("r_pc", pc, model_pc);
            chk("r_count", instr_count, model_count);
            if (redirect) begin
                chk("r_set", pc_set_enable, 1);
                chk("r_set_operand", pc_operand, redirect_target);
                chk("r_redir_req", bus.mem_req, 0);
                chk("r_redir_valid", bus.instr_valid, 0);
                chk("r_redir_upd", pc_update_enable, 0);
                model_pc = redirect_target;
            end else begin
                chk("r_noset", pc_set_enable, 0);
                chk("r_operand", pc_operand, 1);
                if (!fetch_enable) chk("r_stall_req", bus.mem_req, 0);
                if (bus.mem_req) chk("r_addr", bus.mem_addr, model_pc);
                if (bus.instr_valid && bus.instr_ready) begin
                    chk("r_upd", pc_update_enable, 1);
                    chk("r_instr_pc", bus.instr_pc, model_pc);
                    chk("r_instr", bus.instr, model_pc ^ 32'hA5);
                    model_pc    = model_pc + 1;
                    model_count = model_count + 1;
                    accepts++;
                end else begin
                    chk("r_noupd", pc_update_enable, 0);
                end
            end
        end
        chk("r_live", (accepts >= 40) ? 32'd1 : 32'd0, 1);

        // Narrow instance: count wraps modulo 16, one accept every two edges
        #1;
        chk("w_progress", (e2 > 40) ? 32'd1 : 32'd0, 1);
        chk("w_count", count2, 32'((((e2 - 1) / 2) % 16)));
        chk("w_pc", pc2, 32'((((e2 - 1) / 2) % 16)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
